irq_ctrl: RTL and testbench

Interrupt controller at the far end of the control unit's `IRQ` input in the unpipelined Beta-style core. It captures rising edges on up to `NSRC` synchronous interrupt sources into a pending register, applies a software-writable mask, and selects the lowest-numbered eligible source. It raises `IRQ` toward the CU only while the CPU is in user mode, then holds the request until the CU acknowledges taking the interrupt trap. It tracks the in-service interrupt until the handler returns to user mode.

---
 rtl/cu_pkg.sv | 16 +
 rtl/prio_enc.sv | 26 ++
 rtl/irq_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared control-unit definitions for the Beta-style core.
//   irq_state_t : interrupt controller FSM states (IDLE / REQ / SERVICE)
//   PCSEL_IRQ   : PCSEL value selecting the interrupt trap vector
//   NSRC_MAX    : largest supported number of interrupt sources
package cu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } irq_state_t;

    localparam logic [2:0] PCSEL_IRQ = 3'b100;
    localparam int         NSRC_MAX  = 32;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any bit of vec is set and the
// index of the lowest set bit (lowest index has highest priority).
//   vec   in  W   request vector
//   valid out 1   at least one bit of vec is set
//   idx   out IW  index of the lowest set bit (0 when valid is low)
module prio_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the control unit's IRQ input.
// Captures rising edges of SRC into PENDING, arbitrates the masked pending
// set (lowest index wins) while the CPU is in user mode, holds IRQ until
// the CU acknowledges the trap, then tracks the in-service source until
// the handler returns to user mode.
//   CLK        in   core clock
//   RESET_N    in   asynchronous active-low reset
//   SRC        in   NSRC synchronous interrupt source levels
//   MASK_WE    in   mask write strobe
//   MASK_WD    in   NSRC new mask value (1 = enabled)
//   SUPERVISOR in   PC[31] of the current instruction
//   IRQ_ACK    in   CU took the IRQ trap this cycle
//   IRQ        out  registered interrupt request
//   IRQ_ID     out  IDW index of requested / in-service source
//   PENDING    out  NSRC pending register
//   MASK       out  NSRC current mask
//   BUSY       out  high in REQ and SERVICE
//   STATE      out  FSM state, for observation
//
// Handshake: IRQ is asserted from a register and stays high until the
// cycle after IRQ_ACK is seen high in REQ; IRQ_ACK in any other state is
// ignored. IRQ_ID is stable from the first IRQ cycle through SERVICE.
module irq_ctrl
    import cu_pkg::*;
#(
    parameter int NSRC = 8,     // legal range 2..NSRC_MAX
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [NSRC-1:0]  SRC,
    input  logic             MASK_WE,
    input  logic [NSRC-1:0]  MASK_WD,
    input  logic             SUPERVISOR,
    input  logic             IRQ_ACK,
    output logic             IRQ,
    output logic [IDW-1:0]   IRQ_ID,
    output logic [NSRC-1:0]  PENDING,
    output logic [NSRC-1:0]  MASK,
    output logic             BUSY,
    output irq_state_t       STATE
);

    irq_state_t      state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] mask_q;
    logic            armed_q;
    logic            sup_q;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic            win_valid;
    logic [IDW-1:0]  win_idx;
    logic            ack_take;

    // src_q resets to 0, so a source held high through reset would look
    // like a fresh edge. armed_q suppresses capture for the first cycle
    // after reset while src_q picks up the real source levels.
    assign rise     = armed_q ? (SRC & ~src_q) : '0;
    assign ack_take = (state_q == REQ) && IRQ_ACK;
    assign clr      = ack_take ? (NSRC'(1) << id_q) : '0;
    assign eligible = pending_q & mask_q;

    prio_enc #(
        .W  (NSRC),
        .IW (IDW)
    ) u_prio_enc (
        .vec   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (win_valid && !SUPERVISOR) begin
                    state_d = REQ;
                    id_d    = win_idx;
                end
            end
            REQ: begin
                // id_q stays frozen here regardless of mask/pending changes.
                if (IRQ_ACK) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                // Handler return is a 1 -> 0 transition of SUPERVISOR.
                if (sup_q && !SUPERVISOR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            id_q      <= '0;
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            armed_q   <= 1'b0;
            sup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            src_q     <= SRC;
            armed_q   <= 1'b1;
            sup_q     <= SUPERVISOR;
            // A new edge on the bit being acknowledged keeps it pending.
            pending_q <= (pending_q & ~clr) | rise;
            if (MASK_WE) begin
                mask_q <= MASK_WD;
            end
        end
    end

    assign IRQ     = (state_q == REQ);
    assign BUSY    = (state_q != IDLE);
    assign IRQ_ID  = id_q;
    assign PENDING = pending_q;
    assign MASK    = mask_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
    import cu_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] src = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wd = '0;
    logic       sup = 1'b0;
    logic       ack = 1'b0;

    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       busy;
    irq_state_t state;

    irq_ctrl #(.NSRC(8)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .SRC        (src),
        .MASK_WE    (mask_we),
        .MASK_WD    (mask_wd),
        .SUPERVISOR (sup),
        .IRQ_ACK    (ack),
        .IRQ        (irq),
        .IRQ_ID     (irq_id),
        .PENDING    (pending),
        .MASK       (mask),
        .BUSY       (busy),
        .STATE      (state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference ----------------
    // phase: 0 = waiting, 1 = requesting, 2 = handler running
    logic [7:0] m_pending, m_mask, m_prev_src;
    logic       m_prev_sup, m_armed;
    int         m_phase, m_id;

    task automatic model_reset();
        m_pending = '0; m_mask = '0; m_prev_src = '0;
        m_prev_sup = 1'b0; m_armed = 1'b0; m_phase = 0; m_id = 0;
    endtask

    // Advance the reference by one clock using the inputs now applied.
    task automatic model_update();
        logic [7:0] elig, rise;
        int win;
        elig = m_pending & m_mask;
        win  = -1;
        for (int i = 0; i < 8; i++) if (elig[i] && win < 0) win = i;
        rise = m_armed ? (src & ~m_prev_src) : 8'h00;
        case (m_phase)
            0: if (win >= 0 && !sup) begin m_phase = 1; m_id = win; end
            1: if (ack) begin m_pending[m_id] = 1'b0; m_phase = 2; end
            default: if (m_prev_sup && !sup) m_phase = 0;
        endcase
        m_pending = m_pending | rise;
        if (mask_we) m_mask = mask_wd;
        m_prev_src = src;
        m_prev_sup = sup;
        m_armed    = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("irq",     {31'd0, irq},     (m_phase == 1) ? 32'd1 : 32'd0);
        check("busy",    {31'd0, busy},    (m_phase != 0) ? 32'd1 : 32'd0);
        check("pending", {24'd0, pending}, {24'd0, m_pending});
        check("mask",    {24'd0, mask},    {24'd0, m_mask});
        if (m_phase != 0) check("irq_id", {29'd0, irq_id}, m_id);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1'b1; mask_wd = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse_src(input logic [7:0] v);
        src = v; step();
        src = '0;
    endtask

    // Wait (bounded) for IRQ, acknowledge it, then run a handler return.
    task automatic serve();
        int n = 0;
        while (!irq && n < 40) begin step(); n++; end
        check("serve_irq_seen", {31'd0, irq}, 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        sup = 1'b1; step();
        sup = 1'b0; step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_irq",     {31'd0, irq},     32'd0);
        check("reset_pending", {24'd0, pending}, 32'd0);
        check("reset_busy",    {31'd0, busy},    32'd0);
        check("reset_mask",    {24'd0, mask},    32'd0);
        model_update();   // align reference with the edge just taken

        // Edge capture and request
        write_mask(8'hFF);
        pulse_src(8'h08);
        check("cap_pending", {24'd0, pending}, 32'h08);
        check("cap_irq_low", {31'd0, irq}, 32'd0);
        step();
        check("req_irq", {31'd0, irq}, 32'd1);
        check("req_id",  {29'd0, irq_id}, 32'd3);
        step(); step(); step();
        ack = 1'b1; step(); ack = 1'b0;
        check("ack_irq",     {31'd0, irq},     32'd0);
        check("ack_pending", {24'd0, pending}, 32'd0);
        check("ack_busy",    {31'd0, busy},    32'd1);
        ack = 1'b1; step(); ack = 1'b0;          // ignored outside REQ
        sup = 1'b1; step();
        sup = 1'b0; step();
        check("return_busy", {31'd0, busy}, 32'd0);

        // Priority and freeze
        pulse_src(8'h24);
        step();
        check("prio_id", {29'd0, irq_id}, 32'd2);
        pulse_src(8'h01);
        step();
        check("freeze_id", {29'd0, irq_id}, 32'd2);
        check("freeze_irq", {31'd0, irq}, 32'd1);
        serve();
        step();
        check("next_id", {29'd0, irq_id}, 32'd0);
        serve();
        serve();                                  // drains source 5
        check("drained", {24'd0, pending}, 32'd0);

        // Masking
        write_mask(8'h00);
        pulse_src(8'h10);
        for (int i = 0; i < 20; i++) step();
        check("masked_irq", {31'd0, irq}, 32'd0);
        check("masked_pending", {24'd0, pending}, 32'h10);
        write_mask(8'h10);
        check("mask_c1_irq", {31'd0, irq}, 32'd0);
        step();
        check("mask_c2_irq", {31'd0, irq}, 32'd1);
        check("mask_c2_id",  {29'd0, irq_id}, 32'd4);
        serve();

        // Supervisor gating and return
        write_mask(8'hFF);
        sup = 1'b1;
        pulse_src(8'h02);
        pulse_src(8'h40);
        step(); step();
        check("sup_irq", {31'd0, irq}, 32'd0);
        check("sup_pending", {24'd0, pending}, 32'h42);
        sup = 1'b0; step();
        check("sup_drop_irq", {31'd0, irq}, 32'd1);
        check("sup_drop_id",  {29'd0, irq_id}, 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        sup = 1'b1; step(); step();
        sup = 1'b0; step();
        check("ret_r1_busy", {31'd0, busy}, 32'd0);
        step();
        check("ret_r2_irq", {31'd0, irq}, 32'd1);
        check("ret_r2_id",  {29'd0, irq_id}, 32'd6);
        serve();

        // Set/clear collision
        pulse_src(8'h10);
        step();
        check("coll_id", {29'd0, irq_id}, 32'd4);
        src = 8'h10; ack = 1'b1; step();
        src = 8'h00; ack = 1'b0;
        check("coll_pending4", {31'd0, pending[4]}, 32'd1);
        sup = 1'b1; step();
        sup = 1'b0; step();
        serve();

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            src     = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            sup     = ($urandom_range(0, 3) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wd = 8'($urandom_range(0, 255));
            step();
        end
        src = '0; sup = 1'b0; ack = 1'b0; mask_we = 1'b0;

        // Asynchronous reset in the middle of REQ
        write_mask(8'hFF);
        step();
        if (busy) serve();
        pulse_src(8'h04);
        step();
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("areset_irq",     {31'd0, irq},     32'd0);
        check("areset_pending", {24'd0, pending}, 32'd0);
        check("areset_mask",    {24'd0, mask},    32'd0);
        check("areset_busy",    {31'd0, busy},    32'd0);
        model_reset();
        src = 8'h01;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        write_mask(8'hFF);
        for (int i = 0; i < 6; i++) step();
        check("held_src_pending", {24'd0, pending}, 32'd0);
        check("held_src_irq",     {31'd0, irq},     32'd0);
        src = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
